vme_system_controller: RTL and testbench

Slot-1 VME system controller for the computie-vme card. It arbitrates the four bus-request levels (BR0–BR3) and drives the BGxIN daisy-chain heads. It raises BCLR when a higher-priority request arrives, and runs the global bus timer that asserts BERR when a data strobe goes unanswered. It sits beside the existing per-master arbitration and data-transfer logic and is enabled only when the card is jumpered as system controller.

---
 rtl/vme_pkg.sv | 53 +++++
 rtl/vme_system_controller_if.sv | 22 ++
 rtl/vme_bus_timer.sv | 61 ++++++
 rtl/vme_system_controller.sv | 142 ++++++++++++++
 tb/tb_vme_system_controller.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vme_pkg.sv
// Shared VME constants, arbiter state encoding and small priority helpers
// used by the slot-1 system controller.
package vme_pkg;

  localparam logic ACTIVE   = 1'b0;
  localparam logic INACTIVE = 1'b1;

  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GRANT  = 2'd1;
  localparam logic [1:0] ST_BUSY   = 2'd2;
  localparam logic [1:0] ST_SETTLE = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    GRANT  = ST_GRANT,
    BUSY   = ST_BUSY,
    SETTLE = ST_SETTLE
  } arb_state_e;

  localparam logic [5:0] AM_A32_USR_DATA = 6'h09;
  localparam logic [5:0] AM_A32_SUP_DATA = 6'h0D;
  localparam logic [5:0] AM_A16_USR      = 6'h29;
  localparam logic [5:0] AM_A16_SUP      = 6'h2D;
  localparam logic [5:0] AM_A24_USR_DATA = 6'h39;
  localparam logic [5:0] AM_A24_SUP_DATA = 6'h3D;

  // Later (higher) levels overwrite earlier ones, so the result is the top active level.
  function automatic logic [1:0] highest_level(input logic [3:0] br_n);
    logic [1:0] lvl;
    lvl = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (br_n[i] == ACTIVE) lvl = 2'(i);
    end
    return lvl;
  endfunction

  function automatic logic higher_request(input logic [3:0] br_n, input logic [1:0] lvl);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > int'(lvl) && br_n[i] == ACTIVE) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic [3:0] grant_onehot_n(input logic [1:0] lvl);
    return ~(4'b0001 << lvl);
  endfunction

endpackage

// File: rtl/vme_system_controller_if.sv
// VME arbitration and bus-timer signals seen by the system controller.
// All signals are active-low as on the backplane.
interface vme_system_controller_if;
  logic [3:0] vme_br;
  logic       vme_bbsy;
  logic [1:0] vme_ds;
  logic       vme_dtack;
  logic       vme_berr_in;
  logic [3:0] vme_bg_out;
  logic       vme_bclr;
  logic       vme_berr_out;

  modport master (
    input  vme_br, vme_bbsy, vme_ds, vme_dtack, vme_berr_in,
    output vme_bg_out, vme_bclr, vme_berr_out
  );

  modport slave (
    output vme_br, vme_bbsy, vme_ds, vme_dtack, vme_berr_in,
    input  vme_bg_out, vme_bclr, vme_berr_out
  );
endinterface

// File: rtl/vme_bus_timer.sv
// Global VME bus timer: counts cycles of an unanswered data strobe and
// raises BERR plus a one-cycle timeout pulse when the limit is hit.
module vme_bus_timer
  import vme_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1600
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] ds_n,
  input  logic       dtack_n,
  input  logic       berr_in_n,
  output logic       berr_out,
  output logic       timeout_pulse
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          berr_q, berr_d;
  logic          pulse_q, pulse_d;
  logic          clear;
  logic          fire;

  // Saturating one past the fire point keeps the pulse to a single cycle.
  always_comb begin
    clear   = (ds_n == 2'b11) || (dtack_n == ACTIVE) || (berr_in_n == ACTIVE);
    fire    = !clear && (cnt_q == CNT_LAST);
    cnt_d   = cnt_q;
    berr_d  = berr_q;
    pulse_d = fire;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
    if (berr_q == ACTIVE) begin
      berr_d = (ds_n == 2'b11) ? INACTIVE : ACTIVE;
    end else if (fire) begin
      berr_d = ACTIVE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      berr_q  <= INACTIVE;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      berr_q  <= berr_d;
      pulse_q <= pulse_d;
    end
  end

  assign berr_out      = berr_q;
  assign timeout_pulse = pulse_q;

endmodule

// File: rtl/vme_system_controller.sv
// Slot-1 VME system controller: BR0-BR3 priority arbiter driving the BGxIN
// chain heads and BCLR, plus the global bus timer.
module vme_system_controller
  import vme_pkg::*;
#(
  parameter int TIMEOUT_CYCLES       = 1600,
  parameter int GRANT_TIMEOUT_CYCLES = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  vme_system_controller_if.master bus,
  output logic [1:0]              granted_level,
  output logic                    timeout_pulse
);

  localparam int GW = $clog2(GRANT_TIMEOUT_CYCLES + 1);
  localparam logic [GW-1:0] GRANT_LAST = GW'(GRANT_TIMEOUT_CYCLES - 1);

  logic [3:0] br_meta_q, br_s_q;
  logic       bbsy_meta_q, bbsy_s_q;
  logic [1:0] ds_meta_q, ds_s_q;
  logic       dtack_meta_q, dtack_s_q;
  logic       berr_in_meta_q, berr_in_s_q;

  // Two-flop synchronizers; idle (inactive) values during reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      br_meta_q      <= 4'hF;
      br_s_q         <= 4'hF;
      bbsy_meta_q    <= INACTIVE;
      bbsy_s_q       <= INACTIVE;
      ds_meta_q      <= 2'b11;
      ds_s_q         <= 2'b11;
      dtack_meta_q   <= INACTIVE;
      dtack_s_q      <= INACTIVE;
      berr_in_meta_q <= INACTIVE;
      berr_in_s_q    <= INACTIVE;
    end else begin
      br_meta_q      <= bus.vme_br;
      br_s_q         <= br_meta_q;
      bbsy_meta_q    <= bus.vme_bbsy;
      bbsy_s_q       <= bbsy_meta_q;
      ds_meta_q      <= bus.vme_ds;
      ds_s_q         <= ds_meta_q;
      dtack_meta_q   <= bus.vme_dtack;
      dtack_s_q      <= dtack_meta_q;
      berr_in_meta_q <= bus.vme_berr_in;
      berr_in_s_q    <= berr_in_meta_q;
    end
  end

  arb_state_e state_q, state_d;
  logic [3:0] bg_q, bg_d;
  logic       bclr_q, bclr_d;
  logic [1:0] lvl_q, lvl_d;
  logic [GW-1:0] gcnt_q, gcnt_d;

  always_comb begin
    state_d = state_q;
    bg_d    = bg_q;
    bclr_d  = bclr_q;
    lvl_d   = lvl_q;
    gcnt_d  = gcnt_q;
    case (state_q)
      IDLE: begin
        bg_d   = 4'hF;
        bclr_d = INACTIVE;
        if (br_s_q != 4'hF && bbsy_s_q == INACTIVE) begin
          lvl_d   = highest_level(br_s_q);
          bg_d    = grant_onehot_n(highest_level(br_s_q));
          gcnt_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        gcnt_d = gcnt_q + GW'(1);
        // BBSY is checked first so a simultaneous BR drop still lands in BUSY.
        if (bbsy_s_q == ACTIVE) begin
          bg_d    = 4'hF;
          state_d = BUSY;
        end else if (br_s_q[lvl_q] == INACTIVE || gcnt_q == GRANT_LAST) begin
          bg_d    = 4'hF;
          state_d = SETTLE;
        end
      end
      BUSY: begin
        bg_d = 4'hF;
        if (bbsy_s_q == INACTIVE) begin
          bclr_d  = INACTIVE;
          state_d = SETTLE;
        end else begin
          bclr_d = higher_request(br_s_q, lvl_q) ? ACTIVE : INACTIVE;
        end
      end
      SETTLE: begin
        bg_d    = 4'hF;
        state_d = IDLE;
      end
      default: begin
        bg_d    = 4'hF;
        bclr_d  = INACTIVE;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bg_q    <= 4'hF;
      bclr_q  <= INACTIVE;
      lvl_q   <= 2'd0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      bg_q    <= bg_d;
      bclr_q  <= bclr_d;
      lvl_q   <= lvl_d;
      gcnt_q  <= gcnt_d;
    end
  end

  logic berr_out;

  vme_bus_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_bus_timer (
    .clock        (clock),
    .reset        (reset),
    .ds_n         (ds_s_q),
    .dtack_n      (dtack_s_q),
    .berr_in_n    (berr_in_s_q),
    .berr_out     (berr_out),
    .timeout_pulse(timeout_pulse)
  );

  assign bus.vme_bg_out   = bg_q;
  assign bus.vme_bclr     = bclr_q;
  assign bus.vme_berr_out = berr_out;
  assign granted_level    = lvl_q;

endmodule

// File: tb/tb_vme_system_controller.sv
// Directed bench for vme_system_controller with a cycle-level behavioural
// model of arbitration and bus timing plus hand-computed spot checks.
module tb_vme_system_controller;

  localparam int TO = 16;
  localparam int GT = 64;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] granted_level;
  logic       timeout_pulse;
  int         errors = 0;
  int         checks = 0;

  vme_system_controller_if bus();

  vme_system_controller #(
    .TIMEOUT_CYCLES      (TO),
    .GRANT_TIMEOUT_CYCLES(GT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .granted_level(granted_level),
    .timeout_pulse(timeout_pulse)
  );

  always #5 clock = ~clock;

  // Model: inputs seen two edges late; owner tracked as "granted level",
  // "bus owned" and "settling" rather than as a state register.
  logic [3:0] m_br1, m_br2;
  logic       m_bbsy1, m_bbsy2;
  logic [1:0] m_ds1, m_ds2;
  logic       m_dt1, m_dt2, m_be1, m_be2;
  int         m_grant_lvl, m_age, m_stuck;
  bit         m_owned, m_settle, m_higher;
  logic [3:0] exp_bg;
  logic       exp_bclr, exp_berr, exp_pulse;
  logic [1:0] exp_lvl;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_br1 = 4'hF; m_br2 = 4'hF; m_bbsy1 = 1; m_bbsy2 = 1;
      m_ds1 = 2'b11; m_ds2 = 2'b11; m_dt1 = 1; m_dt2 = 1; m_be1 = 1; m_be2 = 1;
      m_grant_lvl = -1; m_age = 0; m_stuck = 0; m_owned = 0; m_settle = 0;
      exp_bg = 4'hF; exp_bclr = 1; exp_berr = 1; exp_pulse = 0; exp_lvl = 2'd0;
    end else begin
      if (m_settle) begin
        m_settle = 0;
      end else if (m_grant_lvl >= 0) begin
        if (!m_bbsy2) begin
          m_grant_lvl = -1; m_owned = 1;
        end else if (m_br2[m_grant_lvl] || m_age == GT - 1) begin
          m_grant_lvl = -1; m_settle = 1;
        end else begin
          m_age++;
        end
      end else if (m_owned) begin
        if (m_bbsy2) begin
          m_owned = 0; m_settle = 1; exp_bclr = 1;
        end else begin
          m_higher = 0;
          for (int i = int'(exp_lvl) + 1; i < 4; i++) if (!m_br2[i]) m_higher = 1;
          exp_bclr = !m_higher;
        end
      end else if (m_br2 != 4'hF && m_bbsy2) begin
        for (int i = 3; i >= 0; i--) if (!m_br2[i] && m_grant_lvl < 0) m_grant_lvl = i;
        m_age = 0;
        exp_lvl = 2'(m_grant_lvl);
      end
      exp_bg = (m_grant_lvl >= 0) ? ~(4'b0001 << m_grant_lvl) : 4'hF;

      if (m_ds2 != 2'b11 && m_dt2 && m_be2) m_stuck++; else m_stuck = 0;
      exp_pulse = (m_stuck == TO);
      if (!exp_berr) begin
        if (m_ds2 == 2'b11) exp_berr = 1;
      end else if (m_stuck == TO) begin
        exp_berr = 0;
      end

      m_br2 = m_br1; m_bbsy2 = m_bbsy1; m_ds2 = m_ds1; m_dt2 = m_dt1; m_be2 = m_be1;
      m_br1 = bus.vme_br; m_bbsy1 = bus.vme_bbsy; m_ds1 = bus.vme_ds;
      m_dt1 = bus.vme_dtack; m_be1 = bus.vme_berr_in;
    end
  end

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    checkOutput("model_bg",    bus.vme_bg_out,          exp_bg);
    checkOutput("model_bclr",  {3'b0, bus.vme_bclr},     {3'b0, exp_bclr});
    checkOutput("model_berr",  {3'b0, bus.vme_berr_out}, {3'b0, exp_berr});
    checkOutput("model_pulse", {3'b0, timeout_pulse},    {3'b0, exp_pulse});
    checkOutput("model_level", {2'b0, granted_level},    {2'b0, exp_lvl});
  end

  task automatic applyStimulus(input logic [3:0] br, input logic bbsy, input logic [1:0] ds,
                               input logic dtack, input logic berr_in);
    @(negedge clock);
    bus.vme_br = br; bus.vme_bbsy = bbsy; bus.vme_ds = ds;
    bus.vme_dtack = dtack; bus.vme_berr_in = berr_in;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic checkAllReset(input string tag);
    checkOutput({tag, "_bg"},    bus.vme_bg_out,          4'hF);
    checkOutput({tag, "_bclr"},  {3'b0, bus.vme_bclr},     4'h1);
    checkOutput({tag, "_berr"},  {3'b0, bus.vme_berr_out}, 4'h1);
    checkOutput({tag, "_level"}, {2'b0, granted_level},    4'h0);
    checkOutput({tag, "_pulse"}, {3'b0, timeout_pulse},    4'h0);
  endtask

  initial begin
    reset = 1'b1;
    bus.vme_br = 4'b0111; bus.vme_bbsy = 1; bus.vme_ds = 2'b11;
    bus.vme_dtack = 1; bus.vme_berr_in = 1;
    waitEdges(3);
    checkAllReset("reset");
    @(negedge clock) reset = 1'b0;
    waitEdges(2);
    checkOutput("br3_edge2_bg", bus.vme_bg_out, 4'hF);
    waitEdges(1);
    checkOutput("br3_edge3_bg", bus.vme_bg_out, 4'b0111);
    checkOutput("br3_level", {2'b0, granted_level}, 4'd3);
    applyStimulus(4'hF, 1, 2'b11, 1, 1);
    waitEdges(8);

    $display("[TB] priority and BBSY handoff");
    applyStimulus(4'b1010, 1, 2'b11, 1, 1);
    waitEdges(3);
    checkOutput("br02_bg", bus.vme_bg_out, 4'b1011);
    checkOutput("br02_level", {2'b0, granted_level}, 4'd2);
    applyStimulus(4'b1010, 0, 2'b11, 1, 1);
    waitEdges(2);
    checkOutput("bbsy_edge2_bg", bus.vme_bg_out, 4'b1011);
    waitEdges(1);
    checkOutput("bbsy_edge3_bg", bus.vme_bg_out, 4'hF);
    applyStimulus(4'b1110, 1, 2'b11, 1, 1);
    waitEdges(4);
    checkOutput("release_edge4_bg", bus.vme_bg_out, 4'hF);
    waitEdges(1);
    checkOutput("release_edge5_bg", bus.vme_bg_out, 4'b1110);
    checkOutput("release_level", {2'b0, granted_level}, 4'd0);
    applyStimulus(4'hF, 1, 2'b11, 1, 1);
    waitEdges(8);

    $display("[TB] grant timeout");
    applyStimulus(4'b1101, 1, 2'b11, 1, 1);
    waitEdges(3);
    checkOutput("gt_start_bg", bus.vme_bg_out, 4'b1101);
    waitEdges(63);
    checkOutput("gt_last_bg", bus.vme_bg_out, 4'b1101);
    waitEdges(1);
    checkOutput("gt_release_bg", bus.vme_bg_out, 4'hF);
    waitEdges(1);
    checkOutput("gt_settle_bg", bus.vme_bg_out, 4'hF);
    waitEdges(1);
    checkOutput("gt_regrant_bg", bus.vme_bg_out, 4'b1101);
    applyStimulus(4'hF, 1, 2'b11, 1, 1);
    waitEdges(8);

    $display("[TB] bus clear");
    applyStimulus(4'b1110, 1, 2'b11, 1, 1);
    waitEdges(3);
    applyStimulus(4'b1110, 0, 2'b11, 1, 1);
    waitEdges(3);
    applyStimulus(4'b1010, 0, 2'b11, 1, 1);
    waitEdges(2);
    checkOutput("bclr_edge2", {3'b0, bus.vme_bclr}, 4'h1);
    waitEdges(1);
    checkOutput("bclr_edge3", {3'b0, bus.vme_bclr}, 4'h0);
    applyStimulus(4'b1110, 0, 2'b11, 1, 1);
    waitEdges(3);
    checkOutput("bclr_drop", {3'b0, bus.vme_bclr}, 4'h1);
    applyStimulus(4'hF, 1, 2'b11, 1, 1);
    waitEdges(6);
    checkOutput("bclr_after_bbsy", {3'b0, bus.vme_bclr}, 4'h1);
    waitEdges(2);

    $display("[TB] bus timer");
    applyStimulus(4'hF, 1, 2'b00, 1, 1);
    waitEdges(TO + 1);
    checkOutput("to_early_berr", {3'b0, bus.vme_berr_out}, 4'h1);
    waitEdges(1);
    checkOutput("to_fire_berr", {3'b0, bus.vme_berr_out}, 4'h0);
    checkOutput("to_fire_pulse", {3'b0, timeout_pulse}, 4'h1);
    waitEdges(1);
    checkOutput("to_pulse_once", {3'b0, timeout_pulse}, 4'h0);
    waitEdges(4);
    applyStimulus(4'hF, 1, 2'b11, 1, 1);
    waitEdges(2);
    checkOutput("to_hold_berr", {3'b0, bus.vme_berr_out}, 4'h0);
    waitEdges(1);
    checkOutput("to_release_berr", {3'b0, bus.vme_berr_out}, 4'h1);
    waitEdges(3);
    applyStimulus(4'hF, 1, 2'b00, 1, 1);
    waitEdges(10);
    applyStimulus(4'hF, 1, 2'b00, 0, 1);
    waitEdges(20);
    checkOutput("dtack_no_berr", {3'b0, bus.vme_berr_out}, 4'h1);
    applyStimulus(4'hF, 1, 2'b11, 1, 1);
    waitEdges(4);

    $display("[TB] simultaneous BBSY and BR drop, then reset");
    applyStimulus(4'b1011, 1, 2'b00, 1, 1);
    waitEdges(3);
    checkOutput("sim_grant_bg", bus.vme_bg_out, 4'b1011);
    applyStimulus(4'hF, 0, 2'b00, 1, 1);
    waitEdges(3);
    checkOutput("sim_release_bg", bus.vme_bg_out, 4'hF);
    applyStimulus(4'b0111, 0, 2'b00, 1, 1);
    waitEdges(3);
    checkOutput("sim_busy_bclr", {3'b0, bus.vme_bclr}, 4'h0);
    waitEdges(10);
    checkOutput("sim_berr_before_reset", {3'b0, bus.vme_berr_out}, 4'h0);
    @(negedge clock);
    #2 reset = 1'b1;
    #1 checkAllReset("async_reset");
    bus.vme_br = 4'hF; bus.vme_bbsy = 1; bus.vme_ds = 2'b11;
    waitEdges(2);
    @(negedge clock) reset = 1'b0;
    waitEdges(2);
    applyStimulus(4'b0111, 1, 2'b11, 1, 1);
    waitEdges(3);
    checkOutput("rearb_bg", bus.vme_bg_out, 4'b0111);
    applyStimulus(4'hF, 1, 2'b11, 1, 1);
    waitEdges(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
